instruction_fetcher: RTL

Byte-to-word instruction fetch stage sitting directly downstream of the byte-wide instruction ROM and upstream of the CPU decode stage. On each request, it performs four sequential single-byte reads from the ROM starting at a word-aligned PC and assembles them little-endian into one 32-bit instruction. The result is presented to the consumer through a valid/ready handshake. Misaligned PCs and out-of-range ROM addresses are reported as fetch errors instead of instructions.

---
 rtl/instruction_fetcher.sv | 99 +++++++++
 1 files changed

// File: rtl/instruction_fetcher.sv
// instruction_fetcher: reads four bytes from a byte-wide combinational ROM,
// assembles them little-endian into a 32-bit instruction and hands the result
// (or a fetch error) to the decode stage through a valid/ready handshake.
module instruction_fetcher (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_pc,
  output logic [31:0] rom_address,
  input  logic [7:0]  rom_read_data,
  input  logic        rom_illegal_address,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        fetch_error,
  output logic        fetch_misaligned,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] base_pc_q;
  logic [1:0]  byte_cnt_q;
  logic [31:0] instr_buf_q;
  logic        err_q;
  logic        mis_q;

  logic        accept_req;
  logic        pc_misaligned;
  logic [4:0]  byte_lsb;

  // A new request is taken when idle, or in the same cycle a response is
  // consumed so that back-to-back fetches lose no cycle.
  assign accept_req    = fetch_req &&
                         ((state_q == IDLE) || ((state_q == RESP) && instr_ready));
  assign pc_misaligned = (fetch_pc[1:0] != 2'b00);
  assign byte_lsb      = {byte_cnt_q, 3'b000};

  // The ROM address walks through the word only while reading; otherwise it
  // parks on the latched PC so the ROM sees a stable address.
  assign rom_address = (state_q == READ) ? (base_pc_q + {30'b0, byte_cnt_q})
                                         : base_pc_q;

  assign instr_valid      = (state_q == RESP);
  assign instruction      = (instr_valid && !err_q) ? instr_buf_q : 32'h0;
  assign fetch_error      = instr_valid && err_q;
  assign fetch_misaligned = instr_valid && mis_q;
  assign busy             = (state_q == READ);

  // Fetch FSM: latch the request, collect bytes until done or faulted, then
  // hold the response until the consumer takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      base_pc_q   <= 32'h0;
      byte_cnt_q  <= 2'd0;
      instr_buf_q <= 32'h0;
      err_q       <= 1'b0;
      mis_q       <= 1'b0;
    end else if (accept_req) begin
      base_pc_q   <= fetch_pc;
      byte_cnt_q  <= 2'd0;
      instr_buf_q <= 32'h0;
      err_q       <= pc_misaligned;
      mis_q       <= pc_misaligned;
      state_q     <= pc_misaligned ? RESP : READ;
    end else begin
      case (state_q)
        READ: begin
          if (rom_illegal_address) begin
            err_q   <= 1'b1;
            mis_q   <= 1'b0;
            state_q <= RESP;
          end else begin
            instr_buf_q[byte_lsb +: 8] <= rom_read_data;
            byte_cnt_q                 <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              state_q <= RESP;
            end
          end
        end
        RESP: begin
          if (instr_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
